// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: answers fetch requests with registered ack/instr/last/err
// after LATENCY cycles, streaming consecutive words while m_i_syn stays high.
module instr_mem_responder #(
    parameter int IWIDTH       = 32,
    parameter int AWIDTH_INSTR = 32,
    parameter int DEPTH        = 256,
    parameter int LATENCY      = 1
) (
    input  logic                       f_clk,
    input  logic                       f_rst,
    input  logic                       m_i_syn,
    input  logic [AWIDTH_INSTR-1:0]    m_i_addr,
    output logic                       m_o_ack,
    output logic [IWIDTH-1:0]          m_o_instr,
    output logic                       m_o_last,
    output logic                       m_o_err,
    input  logic                       m_i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   m_i_wr_idx,
    input  logic [IWIDTH-1:0]          m_i_wr_data,
    input  logic [$clog2(DEPTH):0]     m_i_prog_len
);
    localparam int                      IDXW      = $clog2(DEPTH);
    localparam logic [3:0]              CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [IDXW:0]           LEN_ONE   = 1;
    localparam logic [AWIDTH_INSTR-1:0] WORD_STEP = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

    typedef struct packed {
        logic              err;
        logic              last;
        logic [IWIDTH-1:0] instr;
    } rsp_t;

    state_t                  state;
    logic [AWIDTH_INSTR-1:0] cur_addr;
    logic [3:0]              cnt;
    logic [IWIDTH-1:0]       mem [DEPTH];

    logic [IDXW-1:0] idx;
    logic            upper_set;
    rsp_t            rsp;

    assign idx       = cur_addr[IDXW+1:2];
    assign upper_set = (cur_addr >> (IDXW + 2)) != '0;

    // Error responses always terminate the burst, so they also carry last.
    always_comb begin
        rsp       = '0;
        rsp.err   = (cur_addr[1:0] != 2'b00) || upper_set || ({1'b0, idx} >= m_i_prog_len);
        rsp.last  = rsp.err || ({1'b0, idx} == (m_i_prog_len - LEN_ONE));
        rsp.instr = rsp.err ? '0 : mem[idx];
    end

    // Preload port; the read in RESP sees the pre-write word on a same-index collision.
    always_ff @(posedge f_clk) begin
        if (m_i_wr_en)
            mem[m_i_wr_idx] <= m_i_wr_data;
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            cnt       <= '0;
            m_o_ack   <= 1'b0;
            m_o_instr <= '0;
            m_o_last  <= 1'b0;
            m_o_err   <= 1'b0;
        end else begin
            m_o_ack   <= 1'b0;
            m_o_instr <= '0;
            m_o_last  <= 1'b0;
            m_o_err   <= 1'b0;
            case (state)
                IDLE: if (m_i_syn) begin
                    cur_addr <= m_i_addr;
                    cnt      <= CNT_LOAD;
                    state    <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    if (!m_i_syn) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1)
                            state <= RESP;
                    end
                end
                RESP: begin
                    m_o_ack   <= 1'b1;
                    m_o_err   <= rsp.err;
                    m_o_last  <= rsp.last;
                    m_o_instr <= rsp.instr;
                    if (rsp.last) begin
                        state <= HOLD;
                    end else if (!m_i_syn) begin
                        state <= IDLE;
                    end else begin
                        cur_addr <= cur_addr + WORD_STEP;
                        cnt      <= CNT_LOAD;
                        state    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                HOLD: if (!m_i_syn) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: one LATENCY=1 and one LATENCY=3 responder sharing clock, reset and preload port.
module tb_instr_mem_responder;
    logic        f_clk = 1'b0;
    logic        f_rst;
    logic        wr_en;
    logic [7:0]  wr_idx;
    logic [31:0] wr_data;
    logic [8:0]  prog_len;

    logic        syn1, ack1, last1, err1;
    logic [31:0] addr1, instr1;
    logic        syn3, ack3, last3, err3;
    logic [31:0] addr3, instr3;

    int errors = 0;
    int checks = 0;

    always #5 f_clk = ~f_clk;

    instr_mem_responder #(.IWIDTH(32), .AWIDTH_INSTR(32), .DEPTH(256), .LATENCY(1)) dut1 (
        .f_clk(f_clk), .f_rst(f_rst), .m_i_syn(syn1), .m_i_addr(addr1),
        .m_o_ack(ack1), .m_o_instr(instr1), .m_o_last(last1), .m_o_err(err1),
        .m_i_wr_en(wr_en), .m_i_wr_idx(wr_idx), .m_i_wr_data(wr_data), .m_i_prog_len(prog_len)
    );

    instr_mem_responder #(.IWIDTH(32), .AWIDTH_INSTR(32), .DEPTH(256), .LATENCY(3)) dut3 (
        .f_clk(f_clk), .f_rst(f_rst), .m_i_syn(syn3), .m_i_addr(addr3),
        .m_o_ack(ack3), .m_o_instr(instr3), .m_o_last(last3), .m_o_err(err3),
        .m_i_wr_en(wr_en), .m_i_wr_idx(wr_idx), .m_i_wr_data(wr_data), .m_i_prog_len(prog_len)
    );

    task automatic tick();
        @(posedge f_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic a, input logic l, input logic e, input logic [31:0] d);
        chk({tag, ".ack"},   {31'd0, ack1},  {31'd0, a});
        chk({tag, ".last"},  {31'd0, last1}, {31'd0, l});
        chk({tag, ".err"},   {31'd0, err1},  {31'd0, e});
        chk({tag, ".instr"}, instr1, d);
    endtask

    task automatic chk3(input string tag, input logic a, input logic l, input logic e, input logic [31:0] d);
        chk({tag, ".ack"},   {31'd0, ack3},  {31'd0, a});
        chk({tag, ".last"},  {31'd0, last3}, {31'd0, l});
        chk({tag, ".err"},   {31'd0, err3},  {31'd0, e});
        chk({tag, ".instr"}, instr3, d);
    endtask

    initial begin
        f_rst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; prog_len = 9'd4;
        syn1 = 1'b0; addr1 = '0; syn3 = 1'b0; addr3 = '0;
        tick(); tick();
        chk1("reset1", 1'b0, 1'b0, 1'b0, 32'h0);
        chk3("reset3", 1'b0, 1'b0, 1'b0, 32'h0);
        f_rst = 1'b1;

        // preload program
        wr_en = 1'b1;
        wr_idx = 8'd0; wr_data = 32'h13;  tick();
        wr_idx = 8'd1; wr_data = 32'h93;  tick();
        wr_idx = 8'd2; wr_data = 32'h113; tick();
        wr_idx = 8'd3; wr_data = 32'h193; tick();
        wr_en = 1'b0;

        // single fetch, LATENCY=1
        syn1 = 1'b1; addr1 = 32'h0; tick();
        syn1 = 1'b0;
        chk1("single_cap", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk1("single_rsp", 1'b1, 1'b0, 1'b0, 32'h13);
        tick(); chk1("single_idle", 1'b0, 1'b0, 1'b0, 32'h0);

        // burst from 0x4 to end of program, then HOLD
        syn1 = 1'b1; addr1 = 32'h4; tick();
        chk1("burst_cap", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk1("burst_w1", 1'b1, 1'b0, 1'b0, 32'h93);
        tick(); chk1("burst_w2", 1'b1, 1'b0, 1'b0, 32'h113);
        tick(); chk1("burst_w3", 1'b1, 1'b1, 1'b0, 32'h193);
        tick(); chk1("hold_a", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk1("hold_b", 1'b0, 1'b0, 1'b0, 32'h0);
        syn1 = 1'b0; tick(); tick();

        // LATENCY=3 abort, then timed request at 0x8
        syn3 = 1'b1; addr3 = 32'h0; tick();
        syn3 = 1'b0;
        tick(); chk3("abort_a", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk3("abort_b", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk3("abort_c", 1'b0, 1'b0, 1'b0, 32'h0);
        syn3 = 1'b1; addr3 = 32'h8; tick();
        tick(); chk3("lat3_n1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk3("lat3_n2", 1'b0, 1'b0, 1'b0, 32'h0);
        syn3 = 1'b0;
        tick(); chk3("lat3_n3", 1'b1, 1'b0, 1'b0, 32'h113);
        tick(); chk3("lat3_after", 1'b0, 1'b0, 1'b0, 32'h0);

        // error responses
        syn1 = 1'b1; addr1 = 32'h2; tick(); syn1 = 1'b0;
        tick(); chk1("err_misalign", 1'b1, 1'b1, 1'b1, 32'h0);
        tick(); chk1("err_clear", 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        syn1 = 1'b1; addr1 = 32'h10; tick(); syn1 = 1'b0;
        tick(); chk1("err_range", 1'b1, 1'b1, 1'b1, 32'h0);
        tick(); tick();
        syn1 = 1'b1; addr1 = 32'h400; tick(); syn1 = 1'b0;
        tick(); chk1("err_upper", 1'b1, 1'b1, 1'b1, 32'h0);
        tick(); tick();
        prog_len = 9'd0;
        syn1 = 1'b1; addr1 = 32'h0; tick(); syn1 = 1'b0;
        tick(); chk1("err_len0", 1'b1, 1'b1, 1'b1, 32'h0);
        prog_len = 9'd4;
        tick(); tick();

        // write/read collision on idx 1
        syn1 = 1'b1; addr1 = 32'h4; tick();
        syn1 = 1'b0; wr_en = 1'b1; wr_idx = 8'd1; wr_data = 32'hDEAD;
        tick(); chk1("coll_old", 1'b1, 1'b0, 1'b0, 32'h93);
        wr_en = 1'b0;
        tick();
        syn1 = 1'b1; addr1 = 32'h4; tick(); syn1 = 1'b0;
        tick(); chk1("coll_new", 1'b1, 1'b0, 1'b0, 32'hDEAD);
        tick();

        // asynchronous reset mid-burst
        syn1 = 1'b1; addr1 = 32'h0; syn3 = 1'b1; addr3 = 32'h0; tick();
        tick(); chk1("prerst", 1'b1, 1'b0, 1'b0, 32'h13);
        f_rst = 1'b0; #1;
        chk1("rst_async1", 1'b0, 1'b0, 1'b0, 32'h0);
        chk3("rst_async3", 1'b0, 1'b0, 1'b0, 32'h0);
        syn1 = 1'b0; syn3 = 1'b0; f_rst = 1'b1;
        tick(); chk1("postrst1_a", 1'b0, 1'b0, 1'b0, 32'h0);
        chk3("postrst3_a", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk3("postrst3_b", 1'b0, 1'b0, 1'b0, 32'h0);
        syn3 = 1'b1; addr3 = 32'hC; tick();
        tick(); chk3("rerun_n1", 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); chk3("rerun_n2", 1'b0, 1'b0, 1'b0, 32'h0);
        syn3 = 1'b0;
        tick(); chk3("rerun_n3", 1'b1, 1'b1, 1'b0, 32'h193);
        tick(); chk3("rerun_after", 1'b0, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder for the fetch handshake: it answers `syn` requests from the instruction-fetch stage with registered `ack`/`instr`/`last` responses after a fixed latency. It auto-increments through consecutive words while `syn` stays high, and marks the final word of the loaded program with `last`. It sits between the fetch stage and a word-addressed program RAM, which testbenches and boot logic preload through a write port.

## Interface
Parameters:
- IWIDTH, 32, instruction width
- AWIDTH_INSTR, 32, byte-address width
- DEPTH, 256, memory depth in words (power of two)
- LATENCY, 1, cycles from request capture to `ack` (legal range 1..15)

Ports:
- f_clk  input  1  clock
- f_rst  input  1  reset, asynchronous, active-low
- m_i_syn  input  1  fetch request; held high for a streaming burst
- m_i_addr  input  AWIDTH_INSTR  byte address of the first word, sampled at capture
- m_o_ack  output  1  one-cycle pulse per returned word
- m_o_instr  output  IWIDTH  returned word, valid only while `m_o_ack` is high
- m_o_last  output  1  qualifies `ack`: final word of the burst
- m_o_err  output  1  qualifies `ack`: misaligned or out-of-range access
- m_i_wr_en  input  1  preload write strobe
- m_i_wr_idx  input  $clog2(DEPTH)  preload word index
- m_i_wr_data  input  IWIDTH  preload data
- m_i_prog_len  input  $clog2(DEPTH)+1  number of valid program words (0..DEPTH)

## Operation
- Word index is `addr[$clog2(DEPTH)+1:2]`. Upper address bits above that range must be zero, otherwise the access is an error.
- States and transitions:
  - IDLE: on `m_i_syn`=1, capture `m_i_addr` into `cur_addr`, load the latency counter with LATENCY-1, and go to WAIT. If LATENCY=1, go straight to RESP on the next cycle.
  - WAIT: decrement the counter each cycle. At 0, go to RESP. If `m_i_syn`=0 in any WAIT cycle, abort to IDLE with no `ack`.
  - RESP: assert `ack` for one cycle with `instr`=mem[idx], and `last`=1 if idx == prog_len-1.
    - Error case: if `cur_addr[1:0]`≠0, idx≥prog_len, or any upper bit is set, then `ack`=1, `err`=1, `last`=1, `instr`=0.
    - After the response:
      - if `last`=0 and `m_i_syn`=1: `cur_addr`+=4, reload the counter, go to WAIT (or stay in RESP when LATENCY=1);
      - if `last`=1: go to HOLD;
      - if `m_i_syn`=0: go to IDLE.
  - HOLD: wait until `m_i_syn`=0, then go to IDLE. A request is never re-armed while `syn` stays high after `last`.
- Writes are accepted in every state. On a same-cycle read and write of the same index, the read returns the old data.
- `m_i_prog_len` is sampled every RESP cycle. Changing it during a burst affects later words only.
- `prog_len`=0: the first response is an error (`err`=1, `last`=1).
- `cur_addr` wraps modulo 2^AWIDTH_INSTR. Wrapped addresses fall under the normal range check.

## Timing
- All outputs are registered. Reset values: `ack`=0, `instr`=0, `last`=0, `err`=0; state=IDLE, `cur_addr`=0, counter=0. Memory contents are not reset.
- Capture happens at edge N (`syn` sampled high in IDLE). `ack` is high in the cycle after edge N+LATENCY.
- Burst throughput: one word per LATENCY cycles. With LATENCY=1, `ack` is high on consecutive cycles.
- `m_o_instr`, `last` and `err` return to 0 in every cycle where `ack`=0.
- `m_i_syn` falling in the same cycle as RESP: the pending `ack` is still delivered, then the next state is IDLE.
- Asynchronous reset mid-burst: outputs clear immediately and state goes to IDLE. No `ack` is produced until a new capture.
- Simultaneous `m_i_wr_en` and `syn` capture: both proceed; the response reads memory at RESP time.

## Test plan
- Single fetch: preload mem[0..3]={0x13,0x93,0x113,0x193}, prog_len=4, LATENCY=1, `syn` pulsed one cycle at addr 0 -> one `ack` with instr=0x13, `last`=0, then IDLE.
- Burst to end: `syn` held from addr 0x4, prog_len=4, LATENCY=1 -> three consecutive acks with 0x93, 0x113, 0x193; `last`=1 on the third; no further acks while `syn` stays high (HOLD).
- Latency 3 with abort: LATENCY=3, `syn` high at addr 0 and dropped 1 cycle after capture -> no `ack`; the next request at addr 8 gives `ack` exactly 3 cycles after capture with 0x113.
- Errors: addr 0x2 -> `ack`, `err`=1, `last`=1, instr=0. Addr 0x10 with prog_len=4 -> same response.
- Write/read collision: write mem[1]=0xDEAD in the RESP cycle of idx 1 -> instr=0x93; a re-fetch of idx 1 returns 0xDEAD.
- Reset mid-burst: assert `f_rst`=0 during WAIT -> `ack`/`instr`/`last`/`err`=0 immediately; after release, a new request works normally.
